// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the ID/EX hazard controller.
// Provides the mul/div FSM state enum, the register address width and the
// encoding of the hard-wired zero register.
package pipeline_pkg;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    typedef enum logic {IDLE, MD_BUSY} md_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift register of in-flight destination registers
// (entry 0 = EX) plus the rs/rt match comparators.
// Ports: clk_i/rst_ni clock and async active-low reset; push_valid_i and
// push_addr_i load entry 0 every edge; rs_addr_i/rt_addr_i are compared
// against every valid entry; rs_match_o/rt_match_o flag a hit ($0 never hits).
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_valid_i,
    input  logic [REG_AW-1:0] push_addr_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    output logic              rs_match_o,
    output logic              rt_match_o
);
    logic [SB_DEPTH-1:0] valid_q;
    logic [REG_AW-1:0]   addr_q [SB_DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) addr_q[i] <= REG_ZERO;
        end else begin
            for (int i = SB_DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
            valid_q[0] <= push_valid_i;
            addr_q[0]  <= push_addr_i;
        end
    end

    always_comb begin
        rs_match_o = 1'b0;
        rt_match_o = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            rs_match_o = rs_match_o | (valid_q[i] && addr_q[i] == rs_addr_i);
            rt_match_o = rt_match_o | (valid_q[i] && addr_q[i] == rt_addr_i);
        end
        rs_match_o = rs_match_o && rs_addr_i != REG_ZERO;
        rt_match_o = rt_match_o && rt_addr_i != REG_ZERO;
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: RAW/mul-div stall and branch flush control for
// the ID/EX register of a 5-stage pipeline without forwarding.
// Ports: clk_i/rst_ni clock and async active-low reset; id_*_i describe the
// instruction in ID; stall_if_o holds PC and IF/ID, id_ex_pause_o inserts a
// bubble, flush_if_id_o clears IF/ID on an issuing taken branch, md_busy_o
// marks the mul/div FSM busy, stall_cycles_o is a saturating stall counter.
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int SB_DEPTH  = 3,
    parameter int MD_CYCLES = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 id_valid_i,
    input  logic [REG_AW-1:0]    id_rs_addr_i,
    input  logic                 id_rs_used_i,
    input  logic [REG_AW-1:0]    id_rt_addr_i,
    input  logic                 id_rt_used_i,
    input  logic [REG_AW-1:0]    id_rd_write_address_i,
    input  logic                 id_rd_write_enable_i,
    input  logic                 id_md_start_i,
    input  logic                 id_branch_taken_i,
    output logic                 stall_if_o,
    output logic                 flush_if_id_o,
    output logic                 id_ex_pause_o,
    output logic                 md_busy_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);
    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    md_state_e            state_q, state_d;
    logic [7:0]           md_cnt_q, md_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic                 rs_match, rt_match, raw, md_busy, stall, issue;

    hazard_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (issue && id_rd_write_enable_i && id_rd_write_address_i != REG_ZERO),
        .push_addr_i  (id_rd_write_address_i),
        .rs_addr_i    (id_rs_addr_i),
        .rt_addr_i    (id_rt_addr_i),
        .rs_match_o   (rs_match),
        .rt_match_o   (rt_match)
    );

    assign raw     = id_valid_i && ((id_rs_used_i && rs_match) || (id_rt_used_i && rt_match));
    assign md_busy = state_q == MD_BUSY;
    assign stall   = raw || md_busy;
    assign issue   = id_valid_i && !stall;

    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        stall_cycles_d = (stall && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
        if (state_q == IDLE) begin
            if (issue && id_md_start_i) begin
                state_d  = MD_BUSY;
                md_cnt_d = MD_LOAD;
            end
        end else begin
            md_cnt_d = md_cnt_q - 8'd1;
            state_d  = (md_cnt_q == 8'd1) ? IDLE : MD_BUSY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Outputs are combinational from ID inputs, so gate them with reset to
    // keep them at 0 while reset is held even if ID shows a taken branch.
    assign stall_if_o     = rst_ni && stall;
    assign id_ex_pause_o  = rst_ni && stall;
    assign flush_if_id_o  = rst_ni && issue && id_branch_taken_i;
    assign md_busy_o      = rst_ni && md_busy;
    assign stall_cycles_o = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random stimulus checked against
// a cycle-indexed model (per-register ready cycle, mul/div end cycle).
module tb_pipeline_hazard_controller;
    localparam int SB = 3;
    localparam int MD = 8;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          id_valid_i = 1'b0;
    logic [4:0]    id_rs_addr_i = '0;
    logic          id_rs_used_i = 1'b0;
    logic [4:0]    id_rt_addr_i = '0;
    logic          id_rt_used_i = 1'b0;
    logic [4:0]    id_rd_write_address_i = '0;
    logic          id_rd_write_enable_i = 1'b0;
    logic          id_md_start_i = 1'b0;
    logic          id_branch_taken_i = 1'b0;
    logic          stall_if_o, flush_if_id_o, id_ex_pause_o, md_busy_o;
    logic [CW-1:0] stall_cycles_o;

    int n_assert = 0;
    int n_fail = 0;
    int cyc;
    int rdy [32];
    int md_end;
    int cnt;
    int stall_seen;
    int flush_seen;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_controller #(.SB_DEPTH(SB), .MD_CYCLES(MD), .CNT_WIDTH(CW)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .id_valid_i            (id_valid_i),
        .id_rs_addr_i          (id_rs_addr_i),
        .id_rs_used_i          (id_rs_used_i),
        .id_rt_addr_i          (id_rt_addr_i),
        .id_rt_used_i          (id_rt_used_i),
        .id_rd_write_address_i (id_rd_write_address_i),
        .id_rd_write_enable_i  (id_rd_write_enable_i),
        .id_md_start_i         (id_md_start_i),
        .id_branch_taken_i     (id_branch_taken_i),
        .stall_if_o            (stall_if_o),
        .flush_if_id_o         (flush_if_id_o),
        .id_ex_pause_o         (id_ex_pause_o),
        .md_busy_o             (md_busy_o),
        .stall_cycles_o        (stall_cycles_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        foreach (rdy[i]) rdy[i] = -100;
        md_end = 0;
        cnt = 0;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; id_rs_addr_i = 0; id_rs_used_i = 0; id_rt_addr_i = 0;
        id_rt_used_i = 0; id_rd_write_address_i = 0; id_rd_write_enable_i = 0;
        id_md_start_i = 0; id_branch_taken_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        idle_inputs();
        #1;
        chk("rst_stall", 32'(stall_if_o), 0);
        chk("rst_count", 32'(stall_cycles_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        model_reset();
        stall_seen = 0;
        flush_seen = 0;
    endtask

    // One ID cycle: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic step(input logic v, input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                        input logic we, input logic md, input logic br);
        logic raw, mdb, stall, issue, flush;
        id_valid_i = v; id_rs_addr_i = rs; id_rs_used_i = rsu; id_rt_addr_i = rt;
        id_rt_used_i = rtu; id_rd_write_address_i = rd; id_rd_write_enable_i = we;
        id_md_start_i = md; id_branch_taken_i = br;
        #1;
        raw = v && ((rsu && rs != 0 && cyc <= rdy[rs]) || (rtu && rt != 0 && cyc <= rdy[rt]));
        mdb = cyc < md_end;
        stall = raw || mdb;
        issue = v && !stall;
        flush = issue && br;
        chk("stall_if", 32'(stall_if_o), 32'(stall));
        chk("id_ex_pause", 32'(id_ex_pause_o), 32'(stall));
        chk("flush_if_id", 32'(flush_if_id_o), 32'(flush));
        chk("md_busy", 32'(md_busy_o), 32'(mdb));
        chk("stall_cycles", 32'(stall_cycles_o), 32'(cnt));
        stall_seen += int'(stall_if_o);
        flush_seen += int'(flush_if_id_o);
        @(posedge clk_i);
        if (stall) cnt = (cnt < (1 << CW) - 1) ? cnt + 1 : cnt;
        if (issue && we && rd != 0) rdy[rd] = cyc + SB;
        if (issue && md) md_end = cyc + MD;
        cyc++;
        @(negedge clk_i);
    endtask

    initial begin
        model_reset();
        // back-to-back dependency through rs
        do_reset();
        step(1, 0, 0, 0, 0, 8, 1, 0, 0);
        repeat (4) step(1, 8, 1, 0, 0, 9, 1, 0, 0);
        chk("b2b_stalls", 32'(stall_seen), 3);
        chk("b2b_count", 32'(stall_cycles_o), 3);
        // $0 producer and unused rt
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1, 4, 1, 0, 0);
        step(1, 0, 0, 0, 0, 8, 1, 0, 0);
        step(1, 2, 1, 8, 0, 5, 1, 0, 0);
        chk("zero_unused_stalls", 32'(stall_seen), 0);
        // mul/div followed by an independent instruction
        do_reset();
        step(1, 1, 1, 2, 1, 3, 1, 1, 0);
        repeat (8) step(1, 5, 1, 6, 1, 7, 1, 0, 0);
        chk("md_stalls", 32'(stall_seen), 7);
        chk("md_count", 32'(stall_cycles_o), 7);
        // taken branch, free and then dependent
        do_reset();
        step(1, 1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 8, 1, 0, 0);
        repeat (4) step(1, 8, 1, 0, 0, 0, 0, 0, 1);
        chk("br_flushes", 32'(flush_seen), 2);
        chk("br_stalls", 32'(stall_seen), 3);
        // counter saturation: 21 stall cycles from three mul/divs
        do_reset();
        repeat (25) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("sat_count", 32'(stall_cycles_o), 15);
        // async reset in the middle of MD_BUSY
        do_reset();
        step(1, 0, 0, 0, 0, 3, 1, 1, 0);
        repeat (3) step(1, 5, 1, 0, 0, 6, 1, 0, 1);
        id_valid_i = 1; id_branch_taken_i = 1;
        #2 rst_ni = 0;
        #1;
        chk("arst_stall", 32'(stall_if_o), 0);
        chk("arst_pause", 32'(id_ex_pause_o), 0);
        chk("arst_flush", 32'(flush_if_id_o), 0);
        chk("arst_md_busy", 32'(md_busy_o), 0);
        chk("arst_count", 32'(stall_cycles_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        model_reset();
        stall_seen = 0;
        step(1, 5, 1, 0, 0, 6, 1, 0, 0);
        chk("arst_no_stall", 32'(stall_seen), 0);
        // random traffic over a small register set to provoke hazards
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the ID/EX pipeline register for the 5-stage MIPS pipeline, which has no forwarding network.
- Keeps a scoreboard of in-flight destination registers and detects RAW hazards against the instruction in ID.
- Drives the ID/EX register's pause input (bubble insertion), the IF/ID hold, and the IF/ID flush on taken branches.
- Holds a small FSM that blocks issue while the multi-cycle mul/div unit is busy.

Parameters:
- SB_DEPTH, 3: in-flight stages tracked after ID (EX, MEM, WB); legal range 1..4.
- MD_CYCLES, 8: EX occupancy of a mul/div instruction, in cycles; legal range 2..255.
- CNT_WIDTH, 16: width of the stall-cycle counter.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- id_valid, input, 1: ID holds a valid instruction.
- id_rs_addr, input, 5: rs source address.
- id_rs_used, input, 1: the instruction reads rs.
- id_rt_addr, input, 5: rt source address.
- id_rt_used, input, 1: the instruction reads rt.
- id_rd_write_address, input, 5: destination register of the ID instruction.
- id_rd_write_enable, input, 1: the ID instruction writes the register file.
- id_md_start, input, 1: the ID instruction is mul/div.
- id_branch_taken, input, 1: a branch is resolved taken in ID.
- stall_if, output, 1: hold PC and IF/ID.
- flush_if_id, output, 1: clear IF/ID.
- id_ex_pause, output, 1: connects to the ID/EX register pause input; inserts a bubble.
- md_busy, output, 1: FSM is in MD_BUSY.
- stall_cycles, output, CNT_WIDTH: saturating count of cycles with stall_if=1.

Behaviour:
- Reset (reset_n=0, async):
  - Scoreboard entries are invalid, FSM goes to IDLE, md counter=0, stall_cycles=0.
  - All outputs are forced to 0 while reset_n is low.
  - Reset mid mul/div abandons the operation; there is no pending stall after release.
- Scoreboard: SB_DEPTH entries of {valid, addr}; entry0 = EX stage.
  - Every clock edge: entry[i] <= entry[i-1].
  - entry0 <= {issue && id_rd_write_enable && id_rd_write_address!=0, id_rd_write_address}.
  - If the instruction does not issue, entry0 is loaded as a bubble (valid=0).
- Data hazard (combinational):
  - raw = id_valid && ((id_rs_used && id_rs_addr!=0 && match(rs)) || (id_rt_used && id_rt_addr!=0 && match(rt))).
  - match(x) = any valid entry with addr==x.
  - Register $0 never creates a hazard.
- FSM states:
  - IDLE: if issue && id_md_start, go to MD_BUSY and load counter=MD_CYCLES-1.
  - MD_BUSY: counter decrements each cycle; when counter==1, go to IDLE on the next edge. The mul/div therefore blocks exactly MD_CYCLES-1 following cycles.
  - md_busy = (state==MD_BUSY).
- Stall and issue:
  - stall = raw || md_busy.
  - issue = id_valid && !stall.
  - stall_if = stall; id_ex_pause = stall (bubble).
  - All stall logic is combinational from the current inputs and registered state, so there is zero added latency: a hazard detected in cycle N produces the bubble at the ID/EX output at edge N+1.
- Branch flush:
  - flush_if_id = issue && id_branch_taken.
  - A stalled branch never flushes; stall has priority.
  - The flush lasts 1 cycle, and the next cycle is re-evaluated.
- id_valid=0: no stall, no flush, and a bubble enters the scoreboard.
- Simultaneous events:
  - raw and md_busy both true: a single stall, counted once.
  - A mul/div that itself has a RAW hazard waits in IDLE until the hazard clears, then issues.
- stall_cycles: increments on each cycle with stall=1 and saturates at all-ones (no wrap).
- A hazard resolves after at most SB_DEPTH stall cycles, as the producer shifts out.

Decomposition:
- Shared package pipeline_pkg holds:
  - the md FSM state enum (IDLE, MD_BUSY);
  - REG_ZERO=5'd0;
  - register address width 5.
- One natural sub-module: hazard_scoreboard (the shift register plus the two match comparators), instantiated once. FSM, stall and flush logic stay in the top level.

Test Plan:
- Back-to-back dependency: issue an instruction writing $8, next instruction reads rs=$8 -> stall_if=id_ex_pause=1 for exactly 3 cycles (SB_DEPTH=3), issue in cycle 4, stall_cycles=3.
- Register $0 and unused operands: producer writes $0, or rt=$8 with id_rt_used=0 -> no stall.
- Mul/div: issue id_md_start with MD_CYCLES=8, followed by an independent instruction -> md_busy=1 for 7 cycles, stall=1 for those 7, issue on the 8th.
- Branch: taken branch with no hazard -> flush_if_id=1 for 1 cycle. Same branch reading a register written by the previous instruction -> flush only in the cycle it finally issues, with 0 flushes during the stall.
- Saturation: CNT_WIDTH=4, force 20 stall cycles -> stall_cycles holds 15.
- Async reset: assert reset_n=0 in the middle of MD_BUSY, between clock edges -> outputs go to 0 immediately; after release, the independent instruction issues with no stall.
